// File: rtl/booth_mul_seq.sv
// booth_mul_seq: sequential radix-2 Booth multiplier that steers an external 6-bit add/sub unit.
// One Booth step per cycle; the add/sub overflow flag recovers the true sign for the shift-in bit.
module booth_mul_seq #(
    parameter int WIDTH = 6
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     mcand,
    input  logic [WIDTH-1:0]     mplier,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [2*WIDTH-1:0]   product,
    output logic [WIDTH-1:0]     au_x,
    output logic [WIDTH-1:0]     au_y,
    output logic                 au_sel,
    input  logic [WIDTH-1:0]     au_sum,
    input  logic                 au_ovf,
    input  logic                 au_cout
);
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    state_t               state_q, state_d;
    logic [WIDTH-1:0]     a_q, a_d, q_q, q_d, m_q, m_d, a_step;
    logic                 qm1_q, qm1_d, use_au, s;
    logic [2:0]           cnt_q, cnt_d;
    logic [2*WIDTH-1:0]   product_q, product_d;
    logic                 unused_cout;
    assign unused_cout = au_cout;
    assign in_ready  = state_q == IDLE;
    assign out_valid = state_q == DONE;
    assign au_x      = a_q;
    assign au_y      = m_q;
    assign product   = product_q;
    // au_sel depends only on registered state, so no loop through the external adder
    assign use_au    = (state_q == RUN) && (q_q[0] ^ qm1_q);
    assign au_sel    = (state_q == RUN) && q_q[0] && !qm1_q;
    assign a_step    = use_au ? au_sum : a_q;
    assign s         = use_au ? au_sum[WIDTH-1] ^ au_ovf : a_q[WIDTH-1];
    always_comb begin
        state_d   = state_q;
        a_d       = a_q;
        q_d       = q_q;
        qm1_d     = qm1_q;
        m_d       = m_q;
        cnt_d     = cnt_q;
        product_d = product_q;
        case (state_q)
            IDLE: if (in_valid) begin
                a_d     = '0;
                q_d     = mplier;
                qm1_d   = 1'b0;
                m_d     = mcand;
                cnt_d   = '0;
                state_d = RUN;
            end
            RUN: begin
                {a_d, q_d, qm1_d} = {s, a_step, q_q};
                cnt_d = cnt_q + 3'd1;
                if (cnt_q == 3'(WIDTH - 1)) begin
                    product_d = {s, a_step, q_q[WIDTH-1:1]};
                    state_d   = DONE;
                end
            end
            DONE: state_d = out_ready ? IDLE : DONE;
            default: state_d = IDLE;
        endcase
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            a_q       <= '0;
            q_q       <= '0;
            qm1_q     <= 1'b0;
            m_q       <= '0;
            cnt_q     <= '0;
            product_q <= '0;
        end else begin
            state_q   <= state_d;
            a_q       <= a_d;
            q_q       <= q_d;
            qm1_q     <= qm1_d;
            m_q       <= m_d;
            cnt_q     <= cnt_d;
            product_q <= product_d;
        end
    end
endmodule

// File: doc/booth_mul_seq.md
# booth_mul_seq

Sequential radix-2 Booth multiplier for 6-bit two's-complement operands, producing a 12-bit signed product in six iterations. It sits directly upstream of the team's 6-bit ripple add/sub unit, driving its operand and `sel` inputs each cycle and consuming its sum and overflow outputs. Operands arrive and products leave over valid/ready handshakes.

## Interface
- `WIDTH`, 6: operand width. Only 6 is supported; the product is `2*WIDTH`.
- `clk` input 1: single clock, rising edge.
- `rst` input 1: asynchronous, active-high reset.
- `in_valid` input 1: operand pair valid.
- `in_ready` output 1: block can accept operands.
- `mcand` input 6: multiplicand M, signed.
- `mplier` input 6: multiplier Q, signed.
- `out_valid` output 1: `product` valid.
- `out_ready` input 1: consumer accepts product.
- `product` output 12: signed M×Q, registered.
- `au_x` output 6: add/sub operand x, equal to accumulator A.
- `au_y` output 6: add/sub operand y, equal to registered M.
- `au_sel` output 1: 1 selects subtract, 0 selects add.
- `au_sum` input 6: add/sub result.
- `au_ovf` input 1: add/sub signed overflow.
- `au_cout` input 1: add/sub carry out. Unused; tie-off only.

## Operation
- Registers: A[5:0], Q[5:0], q_m1 (1 bit), M[5:0], cnt[2:0], state ∈ {IDLE, RUN, DONE}, product[11:0].
- IDLE: `in_ready`=1. On `in_valid`&&`in_ready`: A←0, Q←`mplier`, q_m1←0, M←`mcand`, cnt←0, go to RUN.
- RUN, one Booth step per cycle, decoded from {Q[0],q_m1}:
  - 01: add, with `au_sel`=0.
  - 10: subtract, with `au_sel`=1.
  - 00 or 11: no-op. `au_sel`=0 and the adder result is ignored.
- Step result:
  - Add/sub step: A' = `au_sum` and s = `au_sum[5]` XOR `au_ovf` (the true sign).
  - No-op step: A' = A and s = A[5].
- Arithmetic right shift: {A,Q,q_m1} ← {s, A', Q}, then cnt←cnt+1.
- When the step with cnt=5 completes: product←{A,Q} after that shift, go to DONE.
- Sign correction through `au_ovf` is mandatory. It makes M=−32 correct, including −32×−32.
- DONE: `out_valid`=1 and `in_ready`=0. On `out_ready`, go to IDLE. `in_valid` is ignored outside IDLE.
- `au_x`/`au_y` always reflect A/M. `au_sel` is driven only in RUN and is 0 elsewhere.
- The path from `au_*` outputs to `au_sum`/`au_ovf` is combinational through the external adder. The block must not add a combinational path from `au_sum` back to `au_x`/`au_y`/`au_sel`.

## Timing
- Reset (asynchronous, any state): state=IDLE, A=Q=M=0, q_m1=0, cnt=0, product=0.
- Output values under reset: `out_valid`=0, `au_sel`=0, `au_x`=`au_y`=0, `in_ready`=1 (decoded from IDLE).
- Reset mid-RUN or in DONE aborts the transaction. No product is emitted for it.
- Latency:
  - Accept edge T0; steps at edges T1..T6.
  - `out_valid`=1 and `product` valid in the cycle after T6.
- `product` and `out_valid` hold stable while `out_ready`=0, for any number of cycles.
- Release:
  - Handshake edge in DONE → IDLE, and `out_valid` drops in the next cycle.
  - `in_ready`=1 from that next cycle on.
- Earliest next accept is one cycle after the release. Minimum period is 8 cycles per product.
- `product` is not cleared on release. It keeps its last value until the next DONE.

## Test plan
- 3×5 → `out_valid` 6 cycles after accept, `product`=0x00F.
- −32×−32 (0x20, 0x20) → `product`=0x400 (+1024). Confirms the `au_ovf` sign correction.
- −32×31 → 0xC20 (−992); 7×−1 → 0xFF9 (−7); 0×−17 → 0x000.
- Backpressure: `out_ready`=0 for 10 cycles in DONE with `in_valid` toggling:
  - `product` and `out_valid` stay stable and `in_ready` stays 0.
  - Release the next cycle, then accept a new operand pair.
- Reset asserted asynchronously mid-edge-cycle after step 3:
  - All outputs take their reset values immediately.
  - `in_ready`=1.
  - The next transaction, 2×−3, gives 0xFFA.
- Random sweep over all 4096 operand pairs against a signed reference model, with random `out_ready` stalls. All products must match.
